// File: rtl/core_pkg.sv
// Shared encodings for the multi-cycle RV32I core: opcodes, ALU op codes,
// datapath select codes and the main control FSM state enumeration.
package core_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned ALU_OP_W = 2;
    localparam int unsigned SEL_W    = 2;

    localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_OP_RTYPE = 2'b10;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ITYPE = 2'b11;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RS2   = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;

    localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] RES_MDR    = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;
    localparam logic [SEL_W-1:0] RES_IMM    = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_BRANCH,
        S_JAL,
        S_LUI
    } state_t;

    // Only beq/bne are implemented among the branches.
    function automatic logic is_legal(input logic [OPCODE_W-1:0] op,
                                      input logic [FUNCT3_W-1:0] f3);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_JAL, OP_LUI: is_legal = 1'b1;
            OP_BRANCH: is_legal = (f3[2:1] == 2'b00);
            default:   is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, driving datapath selects and write strobes.
module multicycle_ctrl
    import core_pkg::*;
#(
    parameter int unsigned ADDR_SEL_W = 1,
    parameter int unsigned MUX_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic [1:0]            alu_op,
    output logic [MUX_W-1:0]      alu_src_a,
    output logic [MUX_W-1:0]      alu_src_b,
    output logic [MUX_W-1:0]      result_src,
    output logic [ADDR_SEL_W-1:0] adr_src,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic                  illegal,
    output logic                  retire
);

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; decode dispatches on the opcode held in the IR.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                state_nxt = S_FETCH;
                if (is_legal(opcode, funct3)) begin
                    case (opcode)
                        OP_R:               state_nxt = S_EXEC_R;
                        OP_I:               state_nxt = S_EXEC_I;
                        OP_LOAD, OP_STORE:  state_nxt = S_MEMADR;
                        OP_BRANCH:          state_nxt = S_BRANCH;
                        OP_JAL:             state_nxt = S_JAL;
                        OP_LUI:             state_nxt = S_LUI;
                        default:            state_nxt = S_FETCH;
                    endcase
                end
            end
            S_EXEC_R:   state_nxt = S_ALUWB;
            S_EXEC_I:   state_nxt = S_ALUWB;
            S_ALUWB:    state_nxt = S_FETCH;
            S_MEMADR:   state_nxt = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_nxt = S_MEMWB;
            S_MEMWB:    state_nxt = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_nxt = S_FETCH;
            S_BRANCH:   state_nxt = S_FETCH;
            S_JAL:      state_nxt = S_ALUWB;
            S_LUI:      state_nxt = S_FETCH;
            default:    state_nxt = S_FETCH;
        endcase
    end

    // Output decode: Moore on state, except the mem_ready and branch zero gating.
    always_comb begin
        alu_op     = ALU_OP_ADD;
        alu_src_a  = MUX_W'(SRCA_PC);
        alu_src_b  = MUX_W'(SRCB_RS2);
        result_src = MUX_W'(RES_ALUOUT);
        adr_src    = ADDR_SEL_W'(1'b0);
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        retire     = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_read   = 1'b1;
                    alu_src_b  = MUX_W'(SRCB_FOUR);
                    result_src = MUX_W'(RES_ALU);
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = MUX_W'(SRCA_OLDPC);
                    alu_src_b = MUX_W'(SRCB_IMM);
                    illegal   = !is_legal(opcode, funct3);
                    retire    = !is_legal(opcode, funct3);
                end
                S_EXEC_R: begin
                    alu_src_a = MUX_W'(SRCA_RS1);
                    alu_src_b = MUX_W'(SRCB_RS2);
                    alu_op    = ALU_OP_RTYPE;
                end
                S_EXEC_I: begin
                    alu_src_a = MUX_W'(SRCA_RS1);
                    alu_src_b = MUX_W'(SRCB_IMM);
                    alu_op    = ALU_OP_ITYPE;
                end
                S_ALUWB: begin
                    result_src = MUX_W'(RES_ALUOUT);
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                end
                S_MEMADR: begin
                    alu_src_a = MUX_W'(SRCA_RS1);
                    alu_src_b = MUX_W'(SRCB_IMM);
                end
                S_MEMREAD: begin
                    mem_read = 1'b1;
                    adr_src  = ADDR_SEL_W'(1'b1);
                end
                S_MEMWB: begin
                    result_src = MUX_W'(RES_MDR);
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_write = 1'b1;
                    adr_src   = ADDR_SEL_W'(1'b1);
                    retire    = mem_ready;
                end
                S_BRANCH: begin
                    alu_src_a  = MUX_W'(SRCA_RS1);
                    alu_src_b  = MUX_W'(SRCB_RS2);
                    alu_op     = ALU_OP_SUB;
                    result_src = MUX_W'(RES_ALUOUT);
                    pc_write   = zero ^ funct3[0];
                    retire     = 1'b1;
                end
                S_JAL: begin
                    // PC takes the target computed in decode; ALU forms the link value.
                    alu_src_a  = MUX_W'(SRCA_OLDPC);
                    alu_src_b  = MUX_W'(SRCB_FOUR);
                    result_src = MUX_W'(RES_ALUOUT);
                    pc_write   = 1'b1;
                end
                S_LUI: begin
                    result_src = MUX_W'(RES_IMM);
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                end
                default: begin
                    alu_op = ALU_OP_ADD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction cycle scripts
// derived from the instruction class, with random waits, operands and resets.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic [1:0] alu_op, alu_src_a, alu_src_b, result_src;
    logic       adr_src, mem_read, mem_write, ir_write, pc_write, reg_write, illegal, retire;

    always #5 clk = ~clk;

    multicycle_ctrl #(.ADDR_SEL_W(1), .MUX_W(2)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .alu_op(alu_op), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .adr_src(adr_src),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .illegal(illegal), .retire(retire)
    );

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5, K_LUI = 6, K_ILL = 7;
    int lat_tbl [8] = '{4, 4, 5, 4, 3, 4, 3, 2};

    int tests = 0;
    int fails = 0;
    int ncyc;
    int abort_at;
    bit aborted;
    bit fetching;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic [15:0] got;

    assign got = {alu_op, alu_src_a, alu_src_b, result_src, adr_src, mem_read,
                  mem_write, ir_write, pc_write, reg_write, illegal, retire};

    function automatic logic [15:0] mk(input logic [1:0] aop, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] rs,
                                       input logic adr, input logic mrd, input logic mwr,
                                       input logic irw, input logic pcw, input logic rgw,
                                       input logic ill, input logic ret);
        return {aop, sa, sb, rs, adr, mrd, mwr, irw, pcw, rgw, ill, ret};
    endfunction

    function automatic int kind_of(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LD;
            7'b0100011: return K_ST;
            7'b1100011: return (f3 == 3'b000 || f3 == 3'b001) ? K_BR : K_ILL;
            7'b1101111: return K_JAL;
            7'b0110111: return K_LUI;
            default:    return K_ILL;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s op=%b f3=%b cyc=%0d got=%h exp=%h", name, cur_op, cur_f3, ncyc, got, exp);
        end
    endtask

    // One clock of stimulus; injects a reset if this is the chosen abort cycle.
    task automatic step(input string name, input logic [15:0] e, input logic rdy, input logic z);
        if (aborted) return;
        @(negedge clk);
        if (ncyc == abort_at) begin
            rst = 1'b1;
            mem_ready = 1'($urandom);
            zero = 1'($urandom);
            #1 check("abort_rst", 16'h0000);
            @(negedge clk);
            mem_ready = 1'($urandom);
            #1 check("abort_hold", 16'h0000);
            aborted = 1'b1;
            return;
        end
        rst = 1'b0;
        opcode = fetching ? 7'($urandom) : cur_op;
        funct3 = fetching ? 3'($urandom) : cur_f3;
        mem_ready = rdy;
        zero = z;
        #1 check(name, e);
        ncyc++;
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int wf,
                             input int wm, input int ab, input logic bz);
        int k;
        logic ill;
        logic r;
        cur_op = op;
        cur_f3 = f3;
        ncyc = 0;
        abort_at = ab;
        aborted = 1'b0;
        k = kind_of(op, f3);
        ill = (k == K_ILL);

        fetching = 1'b1;
        for (int i = 0; i <= wf; i++) begin
            r = (i == wf);
            step("fetch", mk(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0, r, r, 1'b0, 1'b0, 1'b0),
                 r, 1'($urandom));
        end
        fetching = 1'b0;
        step("decode", mk(2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ill, ill),
             1'($urandom), 1'($urandom));

        case (k)
            K_R, K_I: begin
                if (k == K_R)
                    step("exec_r", mk(2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0),
                         1'($urandom), 1'($urandom));
                else
                    step("exec_i", mk(2'b11, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0),
                         1'($urandom), 1'($urandom));
                step("aluwb", mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1),
                     1'($urandom), 1'($urandom));
            end
            K_LD, K_ST: begin
                step("memadr", mk(2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0),
                     1'($urandom), 1'($urandom));
                for (int i = 0; i <= wm; i++) begin
                    r = (i == wm);
                    if (k == K_LD)
                        step("memread", mk(2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0),
                             r, 1'($urandom));
                    else
                        step("memwrite", mk(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 0, r),
                             r, 1'($urandom));
                end
                if (k == K_LD)
                    step("memwb", mk(2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 0, 1, 0, 1),
                         1'($urandom), 1'($urandom));
            end
            K_BR: begin
                step("branch", mk(2'b01, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, bz ^ f3[0], 0, 0, 1),
                     1'($urandom), bz);
            end
            K_JAL: begin
                step("jal", mk(2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0),
                     1'($urandom), 1'($urandom));
                step("aluwb", mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1),
                     1'($urandom), 1'($urandom));
            end
            K_LUI: begin
                step("lui", mk(2'b00, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0, 1, 0, 1),
                     1'($urandom), 1'($urandom));
            end
            default: ;
        endcase

        if (!aborted) begin
            int exp_lat;
            exp_lat = lat_tbl[k] + wf + ((k == K_LD || k == K_ST) ? wm : 0);
            tests++;
            if (ncyc != exp_lat) begin
                fails++;
                $display("FAIL latency op=%b got=%0d exp=%0d", op, ncyc, exp_lat);
            end
        end
    endtask

    initial begin
        logic [6:0] ops [7];
        logic [6:0] rop;
        int sel;
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011; ops[3] = 7'b0100011;
        ops[4] = 7'b1100011; ops[5] = 7'b1101111; ops[6] = 7'b0110111;

        rst = 1'b1;
        opcode = 7'b0;
        funct3 = 3'b0;
        zero = 1'b0;
        mem_ready = 1'b0;
        ncyc = 0;
        abort_at = -1;
        aborted = 1'b0;
        fetching = 1'b0;
        cur_op = 7'b0;
        cur_f3 = 3'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom);
            opcode = 7'($urandom);
            zero = 1'($urandom);
            #1 check("reset_hold", 16'h0000);
        end

        run_instr(7'b0110011, 3'b000, 0, 0, -1, 1'b0);   // add
        run_instr(7'b0000011, 3'b010, 0, 2, -1, 1'b0);   // lw with 2 wait cycles
        run_instr(7'b1100011, 3'b000, 0, 0, -1, 1'b1);   // beq taken
        run_instr(7'b1100011, 3'b000, 0, 0, -1, 1'b0);   // beq not taken
        run_instr(7'b1100011, 3'b001, 0, 0, -1, 1'b0);   // bne taken
        run_instr(7'b1110011, 3'b000, 0, 0, -1, 1'b0);   // unsupported opcode
        run_instr(7'b1100011, 3'b010, 0, 0, -1, 1'b0);   // unsupported branch funct3
        run_instr(7'b0100011, 3'b010, 1, 1, -1, 1'b0);   // sw
        run_instr(7'b1101111, 3'b000, 0, 0, -1, 1'b0);   // jal
        run_instr(7'b0110111, 3'b000, 2, 0, -1, 1'b0);   // lui with fetch wait
        run_instr(7'b0010011, 3'b000, 0, 0, -1, 1'b0);   // addi
        run_instr(7'b0100011, 3'b010, 0, 3, 3, 1'b0);    // sw aborted in MEMWRITE
        run_instr(7'b0110011, 3'b000, 0, 0, -1, 1'b0);   // clean restart after abort

        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 8);
            if (sel < 7) rop = ops[sel];
            else if (sel == 7) rop = 7'b1100011;
            else rop = 7'($urandom);
            run_instr(rop, 3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 19) == 0) ? $urandom_range(0, 6) : -1, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
